ma_lsu: RTL and testbench

//  MA-stage load/store unit, directly downstream of the EX-stage executor. Takes the executor

---
 rtl/ma_lsu_if.sv | 38 +++
 rtl/ma_lsu.sv | 145 ++++++++++++++
 tb/tb_ma_lsu.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ma_lsu_if.sv
// rtl/ma_lsu_if.sv - pipeline-side and data-bus signals of the MA-stage load/store unit
interface ma_lsu_if;
  logic        s_flush_i;
  logic        s_valid_i;
  logic        s_we_i;
  logic [1:0]  s_size_i;
  logic        s_unsigned_i;
  logic [31:0] s_addr_i;
  logic [31:0] s_wdata_i;
  logic        s_busy_o;
  logic        s_done_o;
  logic [31:0] s_rdata_o;
  logic        s_misalign_o;
  logic        s_buserr_o;
  logic        s_hreq_o;
  logic        s_hwe_o;
  logic [31:0] s_haddr_o;
  logic [3:0]  s_hbe_o;
  logic [31:0] s_hwdata_o;
  logic        s_hgnt_i;
  logic        s_hrvalid_i;
  logic [31:0] s_hrdata_i;
  logic        s_herr_i;

  modport slave (
    input  s_flush_i, s_valid_i, s_we_i, s_size_i, s_unsigned_i, s_addr_i, s_wdata_i,
           s_hgnt_i, s_hrvalid_i, s_hrdata_i, s_herr_i,
    output s_busy_o, s_done_o, s_rdata_o, s_misalign_o, s_buserr_o,
           s_hreq_o, s_hwe_o, s_haddr_o, s_hbe_o, s_hwdata_o
  );

  modport master (
    output s_flush_i, s_valid_i, s_we_i, s_size_i, s_unsigned_i, s_addr_i, s_wdata_i,
           s_hgnt_i, s_hrvalid_i, s_hrdata_i, s_herr_i,
    input  s_busy_o, s_done_o, s_rdata_o, s_misalign_o, s_buserr_o,
           s_hreq_o, s_hwe_o, s_haddr_o, s_hbe_o, s_hwdata_o
  );
endinterface

// File: rtl/ma_lsu.sv
// rtl/ma_lsu.sv - MA-stage load/store unit, one bus transaction per access
// Optional WAIT timeout enabled by defining LSU_BUS_TIMEOUT_EN.
module ma_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic    s_clk_i,
  input  logic    s_resetn_i,
  ma_lsu_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t      state;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  lat_off;
  logic        flushed;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane;
  logic [31:0] load_fmt;

  assign misaligned = (bus.s_size_i == 2'b01 && bus.s_addr_i[0]) ||
                      (bus.s_size_i == 2'b10 && bus.s_addr_i[1:0] != 2'b00) ||
                      (bus.s_size_i == 2'b11);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = bus.s_wdata_i;
    case (bus.s_size_i)
      2'b00: begin
        be_next    = 4'b0001 << bus.s_addr_i[1:0];
        wdata_next = {4{bus.s_wdata_i[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << bus.s_addr_i[1:0];
        wdata_next = {2{bus.s_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane is picked with the offset latched at request time, not the live address.
  always_comb begin
    lane     = bus.s_hrdata_i >> {lat_off, 3'b000};
    load_fmt = lane;
    case (lat_size)
      2'b00:   load_fmt = {{24{~lat_uns & lane[7]}}, lane[7:0]};
      2'b01:   load_fmt = {{16{~lat_uns & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state            <= ST_IDLE;
      lat_size         <= 2'b00;
      lat_uns          <= 1'b0;
      lat_off          <= 2'b00;
      flushed          <= 1'b0;
      bus.s_busy_o     <= 1'b0;
      bus.s_done_o     <= 1'b0;
      bus.s_rdata_o    <= 32'h0;
      bus.s_misalign_o <= 1'b0;
      bus.s_buserr_o   <= 1'b0;
      bus.s_hreq_o     <= 1'b0;
      bus.s_hwe_o      <= 1'b0;
      bus.s_haddr_o    <= 32'h0;
      bus.s_hbe_o      <= 4'h0;
      bus.s_hwdata_o   <= 32'h0;
`ifdef LSU_BUS_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      bus.s_done_o     <= 1'b0;
      bus.s_misalign_o <= 1'b0;
      bus.s_buserr_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.s_valid_i && misaligned) begin
            bus.s_misalign_o <= 1'b1;
          end else if (bus.s_valid_i) begin
            lat_size       <= bus.s_size_i;
            lat_uns        <= bus.s_unsigned_i;
            lat_off        <= bus.s_addr_i[1:0];
            bus.s_hwe_o    <= bus.s_we_i;
            bus.s_haddr_o  <= {bus.s_addr_i[31:2], 2'b00};
            bus.s_hbe_o    <= be_next;
            bus.s_hwdata_o <= wdata_next;
            bus.s_hreq_o   <= 1'b1;
            bus.s_busy_o   <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Grant beats a same-cycle flush: the bus has already committed.
          if (bus.s_hgnt_i) begin
            bus.s_hreq_o <= 1'b0;
            flushed      <= 1'b0;
            state        <= ST_WAIT;
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end else if (bus.s_flush_i) begin
            bus.s_hreq_o <= 1'b0;
            bus.s_busy_o <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.s_flush_i) flushed <= 1'b1;
          if (bus.s_hrvalid_i) begin
            bus.s_busy_o <= 1'b0;
            state        <= ST_IDLE;
            if (!(flushed || bus.s_flush_i)) begin
              bus.s_done_o   <= ~bus.s_herr_i;
              bus.s_buserr_o <= bus.s_herr_i;
              if (!bus.s_hwe_o && !bus.s_herr_i) bus.s_rdata_o <= load_fmt;
            end
          end
`ifdef LSU_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            bus.s_busy_o   <= 1'b0;
            bus.s_buserr_o <= ~(flushed || bus.s_flush_i);
            state          <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_lsu.sv
// tb/tb_ma_lsu.sv - randomized and directed bench for ma_lsu against a behavioural model
module tb_ma_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  ma_lsu_if bus ();

  ma_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .s_clk_i    (clk),
    .s_resetn_i (rst_n),
    .bus        (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int nbytes = 1 << size;
    return 4'(((1 << nbytes) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
    int nbytes = 1 << size;
    logic [31:0] w = 0;
    for (int k = 0; k < 4; k++)
      w = w | (((wdata >> (8 * (k % nbytes))) & 32'hFF) << (8 * k));
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] v = word >> (8 * (addr % 4));
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic access(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_dly, input int rsp_dly, input bit err,
                        input logic [31:0] rword, input int flush_at, input bit flush_wait);
    bit mis = m_misaligned(size, addr);
    bit sup;
    chk("idle_busy_before_valid", bus.s_busy_o, 1'b0);
    bus.s_valid_i = 1'b1; bus.s_we_i = we; bus.s_size_i = size;
    bus.s_unsigned_i = uns; bus.s_addr_i = addr; bus.s_wdata_i = wdata;
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    if (mis) begin
      chk("misalign_pulse", bus.s_misalign_o, 1'b1);
      chk("misalign_no_hreq", bus.s_hreq_o, 1'b0);
      chk("misalign_no_busy", bus.s_busy_o, 1'b0);
      @(negedge clk);
      chk("misalign_pulse_end", bus.s_misalign_o, 1'b0);
      chk("misalign_hreq_still0", bus.s_hreq_o, 1'b0);
      return;
    end
    chk("req_hreq", bus.s_hreq_o, 1'b1);
    chk("req_busy", bus.s_busy_o, 1'b1);
    chk("req_haddr", bus.s_haddr_o, addr & 32'hFFFF_FFFC);
    chk("req_hbe", bus.s_hbe_o, m_be(size, addr));
    chk("req_hwe", bus.s_hwe_o, we);
    if (we) chk("req_hwdata", bus.s_hwdata_o, m_wdata(size, wdata));
    for (int i = 0; i < gnt_dly; i++) begin
      bus.s_flush_i = (i == flush_at);
      @(negedge clk);
      bus.s_flush_i = 1'b0;
      if (i == flush_at) begin
        chk("flush_hreq_drop", bus.s_hreq_o, 1'b0);
        chk("flush_busy_drop", bus.s_busy_o, 1'b0);
        @(negedge clk);
        chk("flush_no_done", bus.s_done_o, 1'b0);
        chk("flush_no_buserr", bus.s_buserr_o, 1'b0);
        return;
      end
      chk("req_hreq_held", bus.s_hreq_o, 1'b1);
      chk("req_haddr_held", bus.s_haddr_o, addr & 32'hFFFF_FFFC);
    end
    bus.s_hgnt_i = 1'b1;
    bus.s_flush_i = (flush_at == gnt_dly);
    @(negedge clk);
    bus.s_hgnt_i = 1'b0; bus.s_flush_i = 1'b0;
    chk("wait_hreq", bus.s_hreq_o, 1'b0);
    chk("wait_busy", bus.s_busy_o, 1'b1);
    for (int i = 0; i < rsp_dly; i++) begin
      bus.s_flush_i = flush_wait && (i == 0);
      @(negedge clk);
      bus.s_flush_i = 1'b0;
      chk("wait_busy_held", bus.s_busy_o, 1'b1);
      chk("wait_no_done", bus.s_done_o, 1'b0);
    end
    bus.s_hrvalid_i = 1'b1; bus.s_hrdata_i = rword; bus.s_herr_i = err;
    @(negedge clk);
    bus.s_hrvalid_i = 1'b0; bus.s_herr_i = 1'b0; bus.s_hrdata_i = $urandom;
    sup = flush_wait && rsp_dly > 0;
    if (!sup && !err && !we) exp_rdata = m_load(size, uns, addr, rword);
    chk("rsp_done", bus.s_done_o, !sup && !err);
    chk("rsp_buserr", bus.s_buserr_o, !sup && err);
    chk("rsp_busy_clear", bus.s_busy_o, 1'b0);
    chk("rsp_rdata", bus.s_rdata_o, exp_rdata);
    @(negedge clk);
    chk("done_pulse_end", bus.s_done_o, 1'b0);
    chk("buserr_pulse_end", bus.s_buserr_o, 1'b0);
    chk("rdata_held", bus.s_rdata_o, exp_rdata);
  endtask

  initial begin
    bus.s_flush_i = 0; bus.s_valid_i = 0; bus.s_we_i = 0; bus.s_size_i = 0;
    bus.s_unsigned_i = 0; bus.s_addr_i = 0; bus.s_wdata_i = 0;
    bus.s_hgnt_i = 0; bus.s_hrvalid_i = 0; bus.s_hrdata_i = 0; bus.s_herr_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.s_busy_o, 1'b0);
    chk("reset_done", bus.s_done_o, 1'b0);
    chk("reset_rdata", bus.s_rdata_o, 32'h0);
    chk("reset_misalign", bus.s_misalign_o, 1'b0);
    chk("reset_buserr", bus.s_buserr_o, 1'b0);
    chk("reset_hreq", bus.s_hreq_o, 1'b0);
    chk("reset_hbe", bus.s_hbe_o, 4'h0);
    chk("reset_haddr", bus.s_haddr_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 2'd2, 0, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF, -1, 0);
    chk("lw_rdata", bus.s_rdata_o, 32'hDEADBEEF);
    access(0, 2'd0, 0, 32'h103, 0, 1, 1, 0, 32'h80123456, -1, 0);
    chk("lb_sign", bus.s_rdata_o, 32'hFFFFFF80);
    access(0, 2'd0, 1, 32'h103, 0, 0, 2, 0, 32'h80123456, -1, 0);
    chk("lbu_zero", bus.s_rdata_o, 32'h00000080);
    access(0, 2'd1, 0, 32'h102, 0, 2, 0, 0, 32'h8001ABCD, -1, 0);
    chk("lh_sign", bus.s_rdata_o, 32'hFFFF8001);
    access(1, 2'd0, 0, 32'h101, 32'h000000A5, 0, 0, 0, 32'h0, -1, 0);
    chk("sb_keeps_rdata", bus.s_rdata_o, 32'hFFFF8001);
    access(0, 2'd2, 0, 32'h102, 0, 0, 0, 0, 0, -1, 0);
    access(0, 2'd1, 0, 32'h101, 0, 0, 0, 0, 0, -1, 0);
    access(1, 2'd3, 0, 32'h100, 0, 0, 0, 0, 0, -1, 0);
    access(0, 2'd2, 0, 32'h200, 0, 5, 0, 0, 32'h11111111, 3, 0);
    access(0, 2'd2, 0, 32'h204, 0, 5, 0, 0, 32'h22222222, 5, 0);
    chk("flush_gnt_completes", bus.s_rdata_o, 32'h22222222);
    access(0, 2'd2, 0, 32'h208, 0, 0, 0, 1, 32'h33333333, -1, 0);
    access(0, 2'd2, 0, 32'h20C, 0, 0, 2, 0, 32'h44444444, -1, 1);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz = 2'($urandom_range(0, 3));
      int fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      access(1'($urandom), sz, 1'($urandom), 32'h1000 + ($urandom & 32'hFF), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
             $urandom, fa, ($urandom_range(0, 5) == 0));
    end

`ifdef LSU_BUS_TIMEOUT_EN
    bus.s_valid_i = 1'b1; bus.s_we_i = 0; bus.s_size_i = 2'd2; bus.s_addr_i = 32'h300;
    @(negedge clk);
    bus.s_valid_i = 1'b0; bus.s_hgnt_i = 1'b1;
    @(negedge clk);
    bus.s_hgnt_i = 1'b0;
    chk("tmo_wait_entry", bus.s_busy_o, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("tmo_not_yet", bus.s_buserr_o, 1'b0);
      chk("tmo_busy_held", bus.s_busy_o, 1'b1);
    end
    @(negedge clk);
    chk("tmo_buserr", bus.s_buserr_o, 1'b1);
    chk("tmo_no_done", bus.s_done_o, 1'b0);
    chk("tmo_busy_clear", bus.s_busy_o, 1'b0);
    bus.s_hrvalid_i = 1'b1;
    @(negedge clk);
    bus.s_hrvalid_i = 1'b0;
    @(negedge clk);
    chk("tmo_late_rsp_no_done", bus.s_done_o, 1'b0);
    chk("tmo_late_rsp_no_buserr", bus.s_buserr_o, 1'b0);
    access(0, 2'd2, 0, 32'h304, 0, 0, 2, 0, 32'h55555555, -1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
